// File: rtl/pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// pc_redirect_ctrl
//
// Fetch-side program-counter unit. Owns the PC register and resolves the
// EX-stage control transfer (conditional branch, JAL, JALR):
//   - computes the transfer target and redirects fetch when it is taken,
//   - requests bubbles in IF/ID and ID/EX for any taken transfer,
//   - traps to TRAP_VEC when a taken target is not 4-byte aligned,
//   - tracks whether the synchronous instruction memory is returning an
//     instruction from the current stream (WAIT / REFILL / RUN),
//   - keeps saturating counters of resolved and taken conditional branches.
//
// Ports
//   clk            in   clock, all state updates on the rising edge
//   rst            in   synchronous active-high reset
//   stall_i        in   hazard stall; holds PC and fetch state
//   ex_valid       in   EX stage holds a valid instruction
//   ex_is_branch   in   EX instruction is a conditional branch
//   ex_is_jal      in   EX instruction is JAL
//   ex_is_jalr     in   EX instruction is JALR
//   br_taken       in   comparator result for the EX branch
//   ex_pc          in   PC of the EX instruction
//   ex_imm         in   sign-extended immediate
//   ex_rs1         in   rs1 operand (JALR base)
//   pc_o           out  current fetch PC
//   pc_plus4_o     out  pc_o + 4 (wraps)
//   fetch_valid_o  out  returned instruction belongs to the current stream
//   redirect_o     out  taken, aligned control transfer this cycle
//   target_o       out  computed transfer target
//   flush_if_id    out  bubble request for IF/ID
//   flush_id_ex    out  bubble request for ID/EX
//   trap_o         out  one-cycle misaligned-target pulse (registered)
//   branch_cnt     out  conditional branches resolved (saturating)
//   taken_cnt      out  conditional branches taken (saturating)
// ---------------------------------------------------------------------------
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic             br_taken,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_rs1,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic             fetch_valid_o,
  output logic             redirect_o,
  output logic [31:0]      target_o,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             trap_o,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  // Fetch stream state. WAIT: first fetch after reset is in flight.
  // REFILL: first fetch after a redirect/trap is in flight. RUN: steady.
  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_REFILL = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  logic [31:0]      r_pc;
  logic [1:0]       r_state;
  logic             r_trap;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  logic [31:0]      w_target;
  logic             w_take;
  logic             w_misalign;
  logic             w_redirect;
  logic             w_count_br;

  // JALR wins when decode flags overlap; its target has bit 0 forced low.
  // NOTE: every combinational output gets a value on every path, so no
  // latch is inferred.
  always_comb begin
    w_target = ex_pc + ex_imm;
    if (ex_is_jalr) begin
      w_target = (ex_rs1 + ex_imm) & ~32'h1;
    end
  end

  assign w_take     = ex_valid & ((ex_is_branch & br_taken) | ex_is_jal | ex_is_jalr);
  // Without compressed instructions any target with bit 1 set is misaligned.
  assign w_misalign = w_take & w_target[1];
  assign w_redirect = w_take & ~w_misalign;
  // Branch statistics only advance when the EX instruction actually retires
  // from EX this cycle, i.e. not while stalled.
  assign w_count_br = ex_valid & ex_is_branch & ~stall_i;

  // Priority: rst > misalign > redirect > stall > sequential increment.
  // A stall never blocks a taken transfer: the wrong-path fetch must die.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_state      <= ST_WAIT;
      r_trap       <= 1'b0;
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
    end else begin
      r_trap <= w_misalign;

      if (w_misalign) begin
        r_pc    <= TRAP_VEC;
        r_state <= ST_REFILL;
      end else if (w_redirect) begin
        r_pc    <= w_target;
        r_state <= ST_REFILL;
      end else if (!stall_i) begin
        r_pc    <= r_pc + 32'd4;
        r_state <= ST_RUN;
      end

      if (w_count_br && (r_branch_cnt != '1)) begin
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      end
      if (w_count_br && br_taken && (r_taken_cnt != '1)) begin
        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
      end
    end
  end

  assign pc_o          = r_pc;
  assign pc_plus4_o    = r_pc + 32'd4;
  assign fetch_valid_o = (r_state == ST_RUN);
  assign redirect_o    = w_redirect;
  assign target_o      = w_target;
  assign flush_if_id   = w_take;
  assign flush_id_ex   = w_take;
  assign trap_o        = r_trap;
  assign branch_cnt    = r_branch_cnt;
  assign taken_cnt     = r_taken_cnt;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_redirect_ctrl
//
// Directed, table-driven bench for pc_redirect_ctrl (CNT_W = 4 so that
// counter saturation is reachable). Each table row is one clock cycle:
// inputs are driven after the falling edge and every output is compared a
// little later, before the next rising edge. Registered outputs therefore
// show the state left by the previous edge; combinational outputs reflect
// the row's own inputs. Multi-cycle corner cases follow as short sequences.
// ---------------------------------------------------------------------------
module tb_pc_redirect_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
  localparam int          CNT_W    = 4;

  logic             clk;
  logic             rst;
  logic             stall_i;
  logic             ex_valid;
  logic             ex_is_branch;
  logic             ex_is_jal;
  logic             ex_is_jalr;
  logic             br_taken;
  logic [31:0]      ex_pc;
  logic [31:0]      ex_imm;
  logic [31:0]      ex_rs1;
  logic [31:0]      pc_o;
  logic [31:0]      pc_plus4_o;
  logic             fetch_valid_o;
  logic             redirect_o;
  logic [31:0]      target_o;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             trap_o;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;

  pc_redirect_ctrl #(
    .RESET_PC (RESET_PC),
    .TRAP_VEC (TRAP_VEC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .ex_valid      (ex_valid),
    .ex_is_branch  (ex_is_branch),
    .ex_is_jal     (ex_is_jal),
    .ex_is_jalr    (ex_is_jalr),
    .br_taken      (br_taken),
    .ex_pc         (ex_pc),
    .ex_imm        (ex_imm),
    .ex_rs1        (ex_rs1),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .fetch_valid_o (fetch_valid_o),
    .redirect_o    (redirect_o),
    .target_o      (target_o),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .trap_o        (trap_o),
    .branch_cnt    (branch_cnt),
    .taken_cnt     (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        chk;
    logic        rst;
    logic        stall;
    logic        valid;
    logic        br;
    logic        jal;
    logic        jalr;
    logic        tk;
    logic [31:0] epc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] pc;
    logic        fv;
    logic        rd;
    logic        fl;
    logic        tr;
    logic [3:0]  bc;
    logic [3:0]  tc;
    logic [31:0] tgt;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t v(
    input logic chk, input logic r, input logic stall, input logic valid,
    input logic br, input logic jal, input logic jalr, input logic tk,
    input logic [31:0] epc, input logic [31:0] imm, input logic [31:0] rs1,
    input logic [31:0] pc, input logic fv, input logic rd, input logic fl,
    input logic tr, input logic [3:0] bc, input logic [3:0] tc,
    input logic [31:0] tgt);
    vec_t t;
    t = '{chk, r, stall, valid, br, jal, jalr, tk, epc, imm, rs1,
          pc, fv, rd, fl, tr, bc, tc, tgt};
    return t;
  endfunction

  // Cycle with no EX activity.
  function automatic vec_t idle(input logic [31:0] pc, input logic fv, input logic tr,
                                input logic [3:0] bc, input logic [3:0] tc);
    return v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, pc, fv, 0, 0, tr, bc, tc, 0);
  endfunction

  // Stalled cycle with no EX activity.
  function automatic vec_t stl(input logic [31:0] pc, input logic fv,
                               input logic [3:0] bc, input logic [3:0] tc);
    return v(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, pc, fv, 0, 0, 0, bc, tc, 0);
  endfunction

  // Reset cycle; outputs are not compared.
  function automatic vec_t rst_row();
    return v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic apply(input vec_t t);
    @(negedge clk);
    rst          = t.rst;
    stall_i      = t.stall;
    ex_valid     = t.valid;
    ex_is_branch = t.br;
    ex_is_jal    = t.jal;
    ex_is_jalr   = t.jalr;
    br_taken     = t.tk;
    ex_pc        = t.epc;
    ex_imm       = t.imm;
    ex_rs1       = t.rs1;
    #1;
    if (t.chk) begin
      check("pc_o",          pc_o,          t.pc);
      check("pc_plus4_o",    pc_plus4_o,    t.pc + 32'd4);
      check("fetch_valid_o", 32'(fetch_valid_o), 32'(t.fv));
      check("redirect_o",    32'(redirect_o),    32'(t.rd));
      check("flush_if_id",   32'(flush_if_id),   32'(t.fl));
      check("flush_id_ex",   32'(flush_id_ex),   32'(t.fl));
      check("trap_o",        32'(trap_o),        32'(t.tr));
      check("branch_cnt",    32'(branch_cnt),    32'(t.bc));
      check("taken_cnt",     32'(taken_cnt),     32'(t.tc));
      if (t.valid) check("target_o", target_o, t.tgt);
    end
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; ex_valid = 1'b0; ex_is_branch = 1'b0;
    ex_is_jal = 1'b0; ex_is_jalr = 1'b0; br_taken = 1'b0;
    ex_pc = '0; ex_imm = '0; ex_rs1 = '0;

    //            chk r st vl br jl jr tk epc           imm      rs1       pc            fv rd fl tr bc tc tgt
    tbl.push_back(rst_row());
    tbl.push_back(idle(32'h0, 0, 0, 0, 0));
    tbl.push_back(idle(32'h4, 1, 0, 0, 0));
    tbl.push_back(idle(32'h8, 1, 0, 0, 0));
    // BEQ taken at 0x40 -> 0x60
    tbl.push_back(v(1, 0, 0, 1, 1, 0, 0, 1, 32'h40,       32'h20,  32'h0,    32'hC,        1, 1, 1, 0, 0, 0, 32'h60));
    tbl.push_back(idle(32'h60, 0, 0, 1, 1));
    tbl.push_back(idle(32'h64, 1, 0, 1, 1));
    // Not-taken branch held by a 2-cycle stall at pc 0x10
    tbl.push_back(rst_row());
    tbl.push_back(idle(32'h0, 0, 0, 0, 0));
    tbl.push_back(idle(32'h4, 1, 0, 0, 0));
    tbl.push_back(idle(32'h8, 1, 0, 0, 0));
    tbl.push_back(idle(32'hC, 1, 0, 0, 0));
    tbl.push_back(v(1, 0, 1, 1, 1, 0, 0, 0, 32'h40,       32'h20,  32'h0,    32'h10,       1, 0, 0, 0, 0, 0, 32'h60));
    tbl.push_back(v(1, 0, 1, 1, 1, 0, 0, 0, 32'h40,       32'h20,  32'h0,    32'h10,       1, 0, 0, 0, 0, 0, 32'h60));
    tbl.push_back(v(1, 0, 0, 1, 1, 0, 0, 0, 32'h40,       32'h20,  32'h0,    32'h10,       1, 0, 0, 0, 0, 0, 32'h60));
    tbl.push_back(idle(32'h14, 1, 0, 1, 0));
    // JALR 0x1003+2 -> 0x1004 with a stall that must be ignored
    tbl.push_back(v(1, 0, 1, 1, 0, 0, 1, 0, 32'h0,        32'h2,   32'h1003, 32'h18,       1, 1, 1, 0, 1, 0, 32'h1004));
    tbl.push_back(idle(32'h1004, 0, 0, 1, 0));
    tbl.push_back(idle(32'h1008, 1, 0, 1, 0));
    // JAL misaligned 0x100+6 -> trap
    tbl.push_back(v(1, 0, 0, 1, 0, 1, 0, 0, 32'h100,      32'h6,   32'h0,    32'h100C,     1, 0, 1, 0, 1, 0, 32'h106));
    tbl.push_back(idle(TRAP_VEC, 0, 1, 1, 0));
    tbl.push_back(idle(TRAP_VEC + 32'h4, 1, 0, 1, 0));
    // Back-to-back redirects: second lands while in REFILL
    tbl.push_back(v(1, 0, 0, 1, 0, 1, 0, 0, 32'h200,      32'h10,  32'h0,    32'h108,      1, 1, 1, 0, 1, 0, 32'h210));
    tbl.push_back(v(1, 0, 0, 1, 0, 1, 0, 0, 32'h300,      32'h8,   32'h0,    32'h210,      0, 1, 1, 0, 1, 0, 32'h308));
    tbl.push_back(idle(32'h308, 0, 0, 1, 0));
    tbl.push_back(stl(32'h30C, 1, 1, 0));
    tbl.push_back(idle(32'h30C, 1, 0, 1, 0));
    tbl.push_back(idle(32'h310, 1, 0, 1, 0));
    // Stall while in REFILL keeps fetch_valid low
    tbl.push_back(v(1, 0, 0, 1, 0, 1, 0, 0, 32'h400,      32'h0,   32'h0,    32'h314,      1, 1, 1, 0, 1, 0, 32'h400));
    tbl.push_back(stl(32'h400, 0, 1, 0));
    tbl.push_back(idle(32'h400, 0, 0, 1, 0));
    tbl.push_back(idle(32'h404, 1, 0, 1, 0));
    // Taken branch to a misaligned target: traps, still counted
    tbl.push_back(v(1, 0, 0, 1, 1, 0, 0, 1, 32'h500,      32'h2,   32'h0,    32'h408,      1, 0, 1, 0, 1, 0, 32'h502));
    tbl.push_back(idle(TRAP_VEC, 0, 1, 2, 1));
    tbl.push_back(idle(TRAP_VEC + 32'h4, 1, 0, 2, 1));
    // Misaligned JALR during a stall still traps
    tbl.push_back(v(1, 0, 1, 1, 0, 0, 1, 0, 32'h0,        32'h2,   32'h10,   32'h108,      1, 0, 1, 0, 2, 1, 32'h12));
    tbl.push_back(idle(TRAP_VEC, 0, 1, 2, 1));
    tbl.push_back(idle(TRAP_VEC + 32'h4, 1, 0, 2, 1));
    // JAL and JALR both set: JALR formula wins
    tbl.push_back(v(1, 0, 0, 1, 0, 1, 1, 0, 32'h0,        32'h20,  32'h41,   32'h108,      1, 1, 1, 0, 2, 1, 32'h60));
    tbl.push_back(idle(32'h60, 0, 0, 2, 1));
    // Target addition wraps mod 2^32
    tbl.push_back(v(1, 0, 0, 1, 0, 1, 0, 0, 32'hFFFF_FFF0, 32'h20,  32'h0,    32'h64,       1, 1, 1, 0, 2, 1, 32'h10));
    tbl.push_back(idle(32'h10, 0, 0, 2, 1));
    // Decode flags without ex_valid do nothing
    tbl.push_back(v(1, 0, 0, 0, 1, 1, 0, 1, 32'h40,       32'h20,  32'h0,    32'h14,       1, 0, 0, 0, 2, 1, 32'h0));
    tbl.push_back(idle(32'h18, 1, 0, 2, 1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // PC increment wraps: redirect to 0xFFFF_FFFC, then step past the top.
    apply(v(0, 0, 0, 1, 0, 1, 0, 0, 32'hFFFF_FFF0, 32'hC, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("wrap_redirect", 32'(redirect_o), 32'h1);
    check("wrap_target", target_o, 32'hFFFF_FFFC);
    apply(idle(32'hFFFF_FFFC, 0, 0, 2, 1));
    check("wrap_plus4", pc_plus4_o, 32'h0);
    apply(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("wrap_pc", pc_o, 32'h0);

    // Counter saturation: 20 taken branches into 4-bit counters.
    apply(rst_row());
    for (int i = 0; i < 20; i++) begin
      apply(v(0, 0, 0, 1, 1, 0, 0, 1, 32'h40, 32'h20, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));
      check("sat_branch_cnt", 32'(branch_cnt), (i > 15) ? 32'd15 : 32'(i));
      check("sat_taken_cnt",  32'(taken_cnt),  (i > 15) ? 32'd15 : 32'(i));
    end
    apply(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("sat_branch_final", 32'(branch_cnt), 32'd15);
    check("sat_taken_final",  32'(taken_cnt),  32'd15);
    check("sat_pc", pc_o, 32'h60);

    // Reset asserted in the same cycle as a taken redirect.
    apply(v(0, 1, 0, 1, 1, 0, 0, 1, 32'h40, 32'h20, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("rst_redir_seen", 32'(redirect_o), 32'h1);
    apply(idle(RESET_PC, 0, 0, 0, 0));

    // Reset asserted in the same cycle as a misaligned transfer.
    apply(v(0, 1, 0, 1, 0, 1, 0, 0, 32'h100, 32'h6, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(idle(RESET_PC, 0, 0, 0, 0));

    // Reset asserted while the trap pulse is showing.
    apply(v(0, 0, 0, 1, 0, 1, 0, 0, 32'h100, 32'h6, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("trap_before_rst", 32'(trap_o), 32'h1);
    check("trap_pc", pc_o, TRAP_VEC);
    apply(idle(RESET_PC, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
